// File: rtl/pitch_mapper.sv
// pitch_mapper: sonar distance -> DDS tuning word.
// Out-of-range rejection, moving-average smoothing, chromatic quantization
// over two octaves from A3, and an optional glide toward each new note.
// Build option: define PITCH_GLIDE_EN to build the glide unit; without it the
// tuning word loads each new target directly.
module pitch_mapper #(
    parameter int MIN_IN      = 2,
    parameter int MAX_IN      = 50,
    parameter int AVG_LOG2    = 2,
    parameter int BAND_LOG2   = 1,
    parameter int MUTE_CNT    = 3,
    parameter int GLIDE_DIV   = 1000,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  distance_in,
    input  logic        valid,
    output logic [31:0] tuning_word,
    output logic [4:0]  note_idx,
    output logic        note_valid,
    output logic        mute
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 9 + AVG_LOG2;
    localparam int CNT_W = $clog2(MUTE_CNT + 1);
    localparam logic [8:0] MIN_V = 9'(MIN_IN);
    localparam logic [8:0] MAX_V = 9'(MAX_IN);
    localparam logic [CNT_W-1:0] MUTE_C = CNT_W'(MUTE_CNT);

    // Tuning word for note k: round(220 * 2^(k/12) * 2^32 / 1e8)
    function automatic logic [31:0] note_word(input logic [4:0] k);
        case (k)
            5'd0:  note_word = 32'd9449;
            5'd1:  note_word = 32'd10011;
            5'd2:  note_word = 32'd10606;
            5'd3:  note_word = 32'd11237;
            5'd4:  note_word = 32'd11905;
            5'd5:  note_word = 32'd12613;
            5'd6:  note_word = 32'd13363;
            5'd7:  note_word = 32'd14157;
            5'd8:  note_word = 32'd14999;
            5'd9:  note_word = 32'd15891;
            5'd10: note_word = 32'd16836;
            5'd11: note_word = 32'd17837;
            5'd12: note_word = 32'd18898;
            5'd13: note_word = 32'd20022;
            5'd14: note_word = 32'd21212;
            5'd15: note_word = 32'd22473;
            5'd16: note_word = 32'd23810;
            5'd17: note_word = 32'd25226;
            5'd18: note_word = 32'd26726;
            5'd19: note_word = 32'd28315;
            5'd20: note_word = 32'd29998;
            5'd21: note_word = 32'd31782;
            5'd22: note_word = 32'd33672;
            5'd23: note_word = 32'd35674;
            default: note_word = 32'd0;
        endcase
    endfunction

    // ---- stage 0: classify and clamp ----
    logic                 in_range;
    logic [CNT_W-1:0]     oor_cnt, oor_inc;
    logic                 mute_evt;
    logic                 s0_vld;
    logic [8:0]           s0_dist;

    assign in_range = (distance_in != 9'd0) && (distance_in <= MAX_V);
    assign oor_inc  = (oor_cnt == MUTE_C) ? oor_cnt : oor_cnt + 1'b1;
    // Mute fires on every out-of-range sample once the run has reached the limit
    assign mute_evt = valid && !in_range && (oor_inc == MUTE_C);

    // Capture in-range samples (clamped) and track the out-of-range run length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_cnt <= '0;
            s0_vld  <= 1'b0;
            s0_dist <= '0;
        end else begin
            s0_vld  <= valid && in_range;
            s0_dist <= (distance_in < MIN_V) ? MIN_V : distance_in;
            if (valid)
                oor_cnt <= in_range ? '0 : oor_inc;
        end
    end

    // ---- stage 1: ring buffer and running sum ----
    logic [8:0]          avg_buf [DEPTH];
    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] wr_ptr;
    logic                primed;
    logic                s1_vld;

    // First sample after (re)priming fills every slot so the average starts flat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) avg_buf[i] <= '0;
            sum    <= '0;
            wr_ptr <= '0;
            primed <= 1'b0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= s0_vld;
            if (s0_vld) begin
                if (!primed) begin
                    for (int i = 0; i < DEPTH; i++) avg_buf[i] <= s0_dist;
                    sum    <= {s0_dist, {AVG_LOG2{1'b0}}};
                    primed <= 1'b1;
                end else begin
                    avg_buf[wr_ptr] <= s0_dist;
                    sum    <= sum + SUM_W'(s0_dist) - SUM_W'(avg_buf[wr_ptr]);
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            // A mute forces the next in-range sample to re-prime
            if (mute_evt) primed <= 1'b0;
        end
    end

    // ---- stage 2: average and quantize ----
    logic [8:0] avg, band;
    logic [4:0] idx_c, s2_idx;
    logic       s2_vld;

    assign avg   = sum[SUM_W-1 -: 9];
    assign band  = (avg - MIN_V) >> BAND_LOG2;
    assign idx_c = (band > 9'd23) ? 5'd23 : band[4:0];

    // Register the quantized note index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_idx <= '0;
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) s2_idx <= idx_c;
        end
    end

    // ---- stage 3: target and output ----
    logic [31:0] s2_word;
    assign s2_word = note_word(s2_idx);

`ifdef PITCH_GLIDE_EN
    localparam int DIV_W = $clog2(GLIDE_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GLIDE_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [31:0]      target_q, gap, gstep, glide_word;
    logic             up;

    assign tick = (div_cnt == DIV_LAST);

    // Free-running glide divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Next glide word: a fraction of the remaining gap, at least 1, never past target
    always_comb begin
        up         = target_q > tuning_word;
        gap        = up ? target_q - tuning_word : tuning_word - target_q;
        gstep      = gap >> GLIDE_SHIFT;
        if (gstep == 32'd0) gstep = 32'd1;
        glide_word = up ? tuning_word + gstep : tuning_word - gstep;
    end
`endif

    // Output update; mute beats a new target, a new target beats a glide tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tuning_word <= '0;
            note_idx    <= '0;
            note_valid  <= 1'b0;
            mute        <= 1'b1;
`ifdef PITCH_GLIDE_EN
            target_q    <= '0;
`endif
        end else begin
            note_valid <= s2_vld;
            if (s2_vld) begin
                note_idx <= s2_idx;
`ifdef PITCH_GLIDE_EN
                target_q <= s2_word;
`endif
            end
            if (mute_evt) begin
                mute        <= 1'b1;
                tuning_word <= '0;
            end else if (s2_vld) begin
`ifdef PITCH_GLIDE_EN
                if (mute) begin
                    mute        <= 1'b0;
                    tuning_word <= s2_word;
                end
`else
                mute        <= 1'b0;
                tuning_word <= s2_word;
`endif
            end
`ifdef PITCH_GLIDE_EN
            else if (tick && !mute && tuning_word != target_q) begin
                tuning_word <= glide_word;
            end
`endif
        end
    end

endmodule

// File: doc/pitch_mapper.md
# pitch_mapper

Converts the sonar's distance samples into the DDS tuning word for the tone generator. It sits between the sonar stage (distance in inches plus a one-cycle `valid` pulse) and the tone generator (32-bit tuning word input). Processing steps:
- Reject out-of-range readings.
- Smooth the distance with a moving average.
- Quantize to a two-octave chromatic scale from A3.
- Optionally glide the output toward each new note.

## Interface
Parameters:
- `MIN_IN`, 2: smallest in-range distance (inches); smaller non-zero readings are clamped up to it.
- `MAX_IN`, 50: largest in-range distance; readings above it, or equal to 0, are out-of-range.
- `AVG_LOG2`, 2: log2 of the moving-average depth (default 4 samples).
- `BAND_LOG2`, 1: log2 of inches per semitone band.
- `MUTE_CNT`, 3: consecutive out-of-range samples that force mute.
- `GLIDE_DIV`, 1000: clock cycles per glide step.
- `GLIDE_SHIFT`, 4: glide step is the remaining difference shifted right by this amount.

Ports:
- `clk` input 1: 100 MHz system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `distance_in` input 9: distance in inches from the sonar.
- `valid` input 1: one-cycle pulse; `distance_in` is sampled only when this is high.
- `tuning_word` output 32: DDS phase increment; 0 means silence.
- `note_idx` output 5: current quantized note, 0..23.
- `note_valid` output 1: one-cycle pulse when a new target note is registered.
- `mute` output 1: high while the output is silenced.

## Operation
- Reset values: `tuning_word`=0, `note_idx`=0, `note_valid`=0, `mute`=1. Reset also clears the average buffer, running sum, write pointer, out-of-range counter, primed flag and glide divider.
- Sample classification:
  - Out-of-range: `distance_in`==0 or `distance_in`>`MAX_IN`. Increments the out-of-range counter, which saturates at `MUTE_CNT`. The buffer is untouched and no `note_valid` is produced.
  - In-range: any other value, clamped to at least `MIN_IN`. Clears the out-of-range counter.
- When the counter reaches `MUTE_CNT`, `mute` goes to 1, `tuning_word` goes to 0 and the primed flag is cleared.
- Averaging uses a 2^`AVG_LOG2`-entry ring buffer with a running sum; the sum width is 9+`AVG_LOG2` bits.
  - Priming: the first in-range sample while not primed is written into every slot (sum = sample << `AVG_LOG2`), and the primed flag is set.
  - Otherwise the sample replaces the oldest slot: sum += new − old, and the pointer wraps modulo the depth.
  - Average = sum >> `AVG_LOG2` (truncating).
- Quantizing: `note_idx` = min((avg − `MIN_IN`) >> `BAND_LOG2`, 23).
- Note table: target word for note k = round(220·2^(k/12)·2^32/10^8).
  - k=0 → 9449, k=4 → 11905, k=12 → 18898.
  - The table is a 24-entry constant ROM.
- Output update on each new target:
  - If `mute` was 1: `mute` clears and `tuning_word` is loaded directly with the target (no glide up from 0).
  - Otherwise the glide unit (or a direct load, per Configuration) moves toward the target.
- Glide unit:
  - A free-running divider counts `GLIDE_DIV` cycles.
  - On each tick, if `tuning_word` ≠ target, it moves toward the target by max(|target − tuning_word| >> `GLIDE_SHIFT`, 1).
  - It never overshoots and stops exactly on the target.
- Simultaneous events:
  - A new target registered in the same cycle as a glide tick takes priority; that tick is skipped and gliding resumes from the current word toward the new target.
  - A mute event overrides both.

## Timing
- Pipeline: `valid` is captured in cycle 0; the buffer and sum update in cycle 1; average and index are registered in cycle 2; the target word, `note_idx` and the one-cycle `note_valid` pulse are registered in cycle 3.
- Unmute and direct load: `tuning_word` equals the target in the same cycle `note_valid` is high.
- Mute: `mute`=1 and `tuning_word`=0 one cycle after the `valid` that carries the `MUTE_CNT`-th consecutive out-of-range sample.
- Back-to-back `valid` pulses every cycle are fully supported; throughput is one sample per cycle.
- Asserting `rst` mid-glide or mid-pipeline immediately forces all reset values. Any in-flight sample is discarded.

## Configuration
- `PITCH_GLIDE_EN` defined: the glide unit is built as described above.
- `PITCH_GLIDE_EN` undefined: no divider or glide logic; `tuning_word` loads the target directly in the `note_valid` cycle. `GLIDE_DIV` and `GLIDE_SHIFT` are ignored.

## Test plan
- Reset, then one `valid` with distance 2 → `mute` falls, `tuning_word`=9449 and `note_idx`=0 exactly 3 cycles after `valid`, with a single `note_valid` pulse.
- After priming with 2, send four samples of 10 → `note_idx` steps 1, 2, 3, 4; the final target is 11905 (average 10).
- Primed at 26 (`note_idx` 12, word 18898); send 0, 60, 200 → `mute`=1 and `tuning_word`=0 one cycle after the third `valid`. Then send 26 → re-primes and `tuning_word`=18898 directly.
- Two out-of-range samples followed by one in-range sample, repeated → `mute` never asserts.
- With the glide enabled, move from word 9449 to 18898 → the first step is +590 after `GLIDE_DIV` cycles, steps are monotone, and the output settles on exactly 18898. Without the glide → 18898 is loaded in the `note_valid` cycle.
- Distance 255 in range via `MAX_IN`=300 → `note_idx` clamps to 23 (word 35674). Also assert `rst` mid-glide → all outputs show reset values within the same cycle.
